// File: rtl/sdram_init_monitor.sv
// Device-side checker for the SDRAM power-up command stream: verifies wait, PRECHARGE-ALL,
// auto-refresh and MRS ordering/spacing, decodes the mode register, and reports done or the first error.
module sdram_init_monitor #(
    parameter int ADDR_WIDTH = 12,
    parameter int PWR_UP_CYC = 20000,
    parameter int TRP_CYC    = 2,
    parameter int TRFC_CYC   = 8,
    parameter int TMRD_CYC   = 2,
    parameter int REF_NUM    = 8,
    parameter int PAGE_LEN   = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            sdram_cmd,
    input  logic [ADDR_WIDTH-1:0] sdram_addr,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] mode_reg,
    output logic [8:0]            burst_len,
    output logic [1:0]            cas_lat,
    output logic [3:0]            ref_cnt,
    output logic                  err,
    output logic [2:0]            err_code
);

    localparam logic [2:0] S_PWRUP    = 3'd0;
    localparam logic [2:0] S_WAIT_PRE = 3'd1;
    localparam logic [2:0] S_REFS     = 3'd2;
    localparam logic [2:0] S_TMRD     = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;
    localparam logic [2:0] S_ERR      = 3'd5;

    localparam logic [2:0] E_EARLY = 3'd1;
    localparam logic [2:0] E_ORDER = 3'd2;
    localparam logic [2:0] E_TIME  = 3'd3;
    localparam logic [2:0] E_MODE  = 3'd4;

    localparam int         PWR_W    = $clog2(PWR_UP_CYC + 1);
    localparam logic [PWR_W-1:0] PWR_LAST = PWR_W'(PWR_UP_CYC - 1);
    localparam logic [7:0] TRP_LIM  = 8'(TRP_CYC);
    localparam logic [7:0] TRFC_LIM = 8'(TRFC_CYC);
    localparam logic [7:0] TMRD_LIM = 8'(TMRD_CYC);
    localparam logic [3:0] REF_MIN  = 4'(REF_NUM);
    localparam logic [8:0] PAGE_BL  = 9'(PAGE_LEN);

    logic [2:0]            state_q, state_d;
    logic [PWR_W-1:0]      pwr_cnt_q, pwr_cnt_d;
    logic [7:0]            gap_cnt_q, gap_cnt_d;
    logic [7:0]            lim_q, lim_d;
    logic [ADDR_WIDTH-1:0] mode_reg_q, mode_reg_d;
    logic [8:0]            burst_len_q, burst_len_d;
    logic [1:0]            cas_lat_q, cas_lat_d;
    logic [3:0]            ref_cnt_q, ref_cnt_d;
    logic [2:0]            err_code_q, err_code_d;

    logic       is_nop, is_pre, is_ref, is_mrs;
    logic       bl_ok, cl_ok, mode_ok;
    logic [8:0] bl_val;
    logic [1:0] cl_val;
    logic       fail;
    logic [2:0] fail_code;

    // A deselected device (cs_n high) sees a NOP whatever the other strobes do.
    assign is_nop = sdram_cmd[3] | (sdram_cmd == 4'b0111);
    assign is_pre = (sdram_cmd == 4'b0010);
    assign is_ref = (sdram_cmd == 4'b0001);
    assign is_mrs = (sdram_cmd == 4'b0000);

    always_comb begin
        bl_ok  = 1'b1;
        bl_val = '0;
        case (sdram_addr[2:0])
            3'b000:  bl_val = 9'd1;
            3'b001:  bl_val = 9'd2;
            3'b010:  bl_val = 9'd4;
            3'b011:  bl_val = 9'd8;
            3'b111:  begin
                if (!sdram_addr[3]) bl_val = PAGE_BL;
                else                bl_ok  = 1'b0;
            end
            default: bl_ok = 1'b0;
        endcase
        cl_ok  = 1'b1;
        cl_val = '0;
        case (sdram_addr[6:4])
            3'b010:  cl_val = 2'd2;
            3'b011:  cl_val = 2'd3;
            default: cl_ok  = 1'b0;
        endcase
        mode_ok = bl_ok & cl_ok;
    end

    always_comb begin
        // NOTE: every signal assigned below gets a default first, so no path can infer a latch.
        state_d     = state_q;
        pwr_cnt_d   = pwr_cnt_q;
        lim_d       = lim_q;
        mode_reg_d  = mode_reg_q;
        burst_len_d = burst_len_q;
        cas_lat_d   = cas_lat_q;
        ref_cnt_d   = ref_cnt_q;
        err_code_d  = err_code_q;
        fail        = 1'b0;
        fail_code   = '0;
        if (!is_nop)                gap_cnt_d = 8'd1;
        else if (gap_cnt_q == 8'hFF) gap_cnt_d = gap_cnt_q;
        else                        gap_cnt_d = gap_cnt_q + 8'd1;

        case (state_q)
            S_PWRUP: begin
                if (!is_nop) begin
                    fail      = 1'b1;
                    fail_code = E_EARLY;
                end else begin
                    pwr_cnt_d = pwr_cnt_q + 1'b1;
                    if (pwr_cnt_q == PWR_LAST) state_d = S_WAIT_PRE;
                end
            end
            S_WAIT_PRE: begin
                if (!is_nop) begin
                    if (is_pre && sdram_addr[10]) begin
                        state_d = S_REFS;
                        lim_d   = TRP_LIM;
                    end else begin
                        fail      = 1'b1;
                        fail_code = E_ORDER;
                    end
                end
            end
            S_REFS: begin
                // Spacing is checked before order, so a too-early wrong command reports timing.
                if (!is_nop) begin
                    if (gap_cnt_q < lim_q) begin
                        fail      = 1'b1;
                        fail_code = E_TIME;
                    end else if (is_ref) begin
                        lim_d = TRFC_LIM;
                        if (ref_cnt_q != 4'hF) ref_cnt_d = ref_cnt_q + 4'd1;
                    end else if (is_mrs && (ref_cnt_q >= REF_MIN)) begin
                        mode_reg_d = sdram_addr;
                        if (mode_ok) begin
                            burst_len_d = bl_val;
                            cas_lat_d   = cl_val;
                            state_d     = S_TMRD;
                        end else begin
                            fail      = 1'b1;
                            fail_code = E_MODE;
                        end
                    end else begin
                        fail      = 1'b1;
                        fail_code = E_ORDER;
                    end
                end
            end
            S_TMRD: begin
                if (!is_nop && (gap_cnt_q < TMRD_LIM)) begin
                    fail      = 1'b1;
                    fail_code = E_TIME;
                end else if (gap_cnt_q >= TMRD_LIM) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (is_mrs) begin
                    mode_reg_d = sdram_addr;
                    if (mode_ok) begin
                        burst_len_d = bl_val;
                        cas_lat_d   = cl_val;
                    end else begin
                        fail      = 1'b1;
                        fail_code = E_MODE;
                    end
                end
            end
            default: ;
        endcase

        // ERR is never left, so the first recorded cause cannot be overwritten.
        if (fail) begin
            state_d    = S_ERR;
            err_code_d = fail_code;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_PWRUP;
            pwr_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            lim_q       <= '0;
            mode_reg_q  <= '0;
            burst_len_q <= '0;
            cas_lat_q   <= '0;
            ref_cnt_q   <= '0;
            err_code_q  <= '0;
        end else begin
            state_q     <= state_d;
            pwr_cnt_q   <= pwr_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            lim_q       <= lim_d;
            mode_reg_q  <= mode_reg_d;
            burst_len_q <= burst_len_d;
            cas_lat_q   <= cas_lat_d;
            ref_cnt_q   <= ref_cnt_d;
            err_code_q  <= err_code_d;
        end
    end

    assign init_done = (state_q == S_DONE);
    assign err       = (state_q == S_ERR);
    assign mode_reg  = mode_reg_q;
    assign burst_len = burst_len_q;
    assign cas_lat   = cas_lat_q;
    assign ref_cnt   = ref_cnt_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_sdram_init_monitor.sv
// Directed bench for sdram_init_monitor: mode-word vector table plus hand-written
// power-up, ordering, spacing, saturation and mid-sequence reset sequences.
module tb_sdram_init_monitor;

    localparam int         AW  = 12;
    localparam int         PWR = 100;
    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] PRE = 4'b0010;
    localparam logic [3:0] REF = 4'b0001;
    localparam logic [3:0] MRS = 4'b0000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    sdram_cmd = NOP;
    logic [AW-1:0] sdram_addr = '0;
    logic          init_done;
    logic [AW-1:0] mode_reg;
    logic [8:0]    burst_len;
    logic [1:0]    cas_lat;
    logic [3:0]    ref_cnt;
    logic          err;
    logic [2:0]    err_code;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic          bad;
        logic [8:0]    bl;
        logic [1:0]    cl;
    } mode_vec_t;

    mode_vec_t vecs [7];

    always #5 clk = ~clk;

    sdram_init_monitor #(
        .ADDR_WIDTH(AW),
        .PWR_UP_CYC(PWR),
        .TRP_CYC   (2),
        .TRFC_CYC  (8),
        .TMRD_CYC  (2),
        .REF_NUM   (8),
        .PAGE_LEN  (256)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sdram_cmd (sdram_cmd),
        .sdram_addr(sdram_addr),
        .init_done (init_done),
        .mode_reg  (mode_reg),
        .burst_len (burst_len),
        .cas_lat   (cas_lat),
        .ref_cnt   (ref_cnt),
        .err       (err),
        .err_code  (err_code)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] all_outs();
        return {init_done, mode_reg, burst_len, cas_lat, ref_cnt, err, err_code};
    endfunction

    // Drive one command, let it be sampled, then look at outputs 1 ns after the edge.
    task automatic send(input logic [3:0] cmd, input logic [AW-1:0] addr);
        sdram_cmd  = cmd;
        sdram_addr = addr;
        @(posedge clk);
        #1;
        sdram_cmd  = NOP;
        sdram_addr = '0;
    endtask

    task automatic nops(input int n);
        repeat (n) send(NOP, '0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sdram_cmd = NOP;
        sdram_addr = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Edges 1..PWR: half deselected (cs_n=1, other strobes active), half true NOP.
    task automatic pwrup();
        repeat (PWR / 2) send(4'b1000, '0);
        nops(PWR - PWR / 2);
    endtask

    task automatic refs(input int n);
        repeat (n) begin
            nops(7);
            send(REF, '0);
        end
    endtask

    task automatic legal_to_mrs(input logic [AW-1:0] word, input int nref);
        pwrup();
        send(PRE, 12'h400);
        refs(nref);
        nops(7);
        send(MRS, word);
    endtask

    task automatic scenario1(input string tag);
        legal_to_mrs(12'h037, 8);
        nops(1);
        check({tag, " done_early"}, 32'(init_done), 32'd0);
        nops(1);
        check({tag, " done"},    32'(init_done), 32'd1);
        check({tag, " bl"},      32'(burst_len), 32'd256);
        check({tag, " cl"},      32'(cas_lat),   32'd3);
        check({tag, " ref_cnt"}, 32'(ref_cnt),   32'd8);
        check({tag, " mode"},    32'(mode_reg),  32'h037);
        check({tag, " err"},     32'({err, err_code}), 32'd0);
    endtask

    initial begin
        vecs[0] = '{12'h037, 1'b0, 9'd256, 2'd3};
        vecs[1] = '{12'h022, 1'b0, 9'd4,   2'd2};
        vecs[2] = '{12'h030, 1'b0, 9'd1,   2'd3};
        vecs[3] = '{12'h023, 1'b0, 9'd8,   2'd2};
        vecs[4] = '{12'h024, 1'b1, 9'd0,   2'd0};
        vecs[5] = '{12'h03F, 1'b1, 9'd0,   2'd0};
        vecs[6] = '{12'h017, 1'b1, 9'd0,   2'd0};

        #2;
        check("reset outs", all_outs(), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        scenario1("s1");
        send(MRS, 12'h022);
        check("remrs bl",   32'(burst_len), 32'd4);
        check("remrs cl",   32'(cas_lat),   32'd2);
        check("remrs mode", 32'(mode_reg),  32'h022);
        send(REF, '0);
        check("done ignores ref", 32'({init_done, ref_cnt, err}), {27'd0, 1'b1, 4'd8, 1'b0});

        // Mode-word table, each applied through a full legal sequence.
        for (int i = 0; i < 7; i++) begin
            do_reset();
            legal_to_mrs(vecs[i].addr, 8);
            nops(2);
            check($sformatf("vec%0d mode", i), 32'(mode_reg), 32'(vecs[i].addr));
            if (vecs[i].bad) begin
                check($sformatf("vec%0d errcode", i), 32'({init_done, err, err_code}), {28'd0, 1'b1, 3'd4});
            end else begin
                check($sformatf("vec%0d done", i), 32'({init_done, err}), 32'b10);
                check($sformatf("vec%0d bl", i), 32'(burst_len), 32'(vecs[i].bl));
                check($sformatf("vec%0d cl", i), 32'(cas_lat),   32'(vecs[i].cl));
            end
        end

        // Command during power-up, and first-error-wins afterwards.
        do_reset();
        nops(49);
        send(PRE, 12'h400);
        check("early pre", 32'({init_done, err, err_code}), {28'd0, 1'b1, 3'd1});
        nops(60);
        send(PRE, 12'h000);
        send(MRS, 12'h037);
        check("first err wins", 32'({init_done, err, err_code}), {28'd0, 1'b1, 3'd1});

        do_reset();
        nops(PWR - 1);
        send(PRE, 12'h400);
        check("pre at last pwrup edge", 32'(err_code), 32'd1);

        // Spacing violations and the exact-limit boundary.
        do_reset();
        pwrup();
        send(PRE, 12'h400);
        nops(7);
        send(REF, '0);
        nops(4);
        send(REF, '0);
        check("ref after 5", 32'({err, err_code}), {28'd0, 1'b1, 3'd3});

        do_reset();
        pwrup();
        send(PRE, 12'h400);
        send(REF, '0);
        check("ref after pre+1", 32'({err, err_code}), {28'd0, 1'b1, 3'd3});

        do_reset();
        pwrup();
        send(PRE, 12'h400);
        nops(1);
        send(REF, '0);
        check("ref after pre+2", 32'({err, ref_cnt}), 32'd1);

        do_reset();
        legal_to_mrs(12'h037, 8);
        send(REF, '0);
        check("cmd during tmrd", 32'({init_done, err, err_code}), {28'd0, 1'b1, 3'd3});

        // Ordering violations.
        do_reset();
        legal_to_mrs(12'h037, 7);
        nops(2);
        check("mrs after 7 refs", 32'({init_done, err, err_code}), {28'd0, 1'b1, 3'd2});

        do_reset();
        pwrup();
        send(PRE, 12'h000);
        check("pre without a10", 32'({err, err_code}), {28'd0, 1'b1, 3'd2});

        do_reset();
        pwrup();
        send(PRE, 12'h400);
        refs(17);
        check("ref_cnt saturates", 32'({err, ref_cnt}), 32'd15);

        // Asynchronous reset in the middle of the refresh phase, then a clean replay.
        do_reset();
        pwrup();
        send(PRE, 12'h400);
        refs(3);
        check("mid ref_cnt", 32'(ref_cnt), 32'd3);
        nops(3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset outs", all_outs(), 32'd0);
        @(posedge clk);
        #1;
        check("held reset outs", all_outs(), 32'd0);
        rst_n = 1'b1;
        scenario1("replay");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
